// File: rtl/regbank_pkg.sv
//------------------------------------------------------------------------------
// regbank_pkg : shared constants and clear-sequencer state encoding
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package regbank_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;
   localparam int ZERO_REG   = 0;

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } regbank_state_e;

endpackage

`default_nettype wire

// File: rtl/regbank_clr_seq.sv
//------------------------------------------------------------------------------
// regbank_clr_seq : post-reset clear sequencer, walks every entry once to zero
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module regbank_clr_seq
   import regbank_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DEPTH  = 1 << ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   output logic              o_busy,
   output logic              o_clr_we,
   output logic [ADDR_W-1:0] o_clr_addr
);

   // Counter is one bit wider than the address so DEPTH == 2**ADDR_W fits
   localparam logic [ADDR_W:0] c_LAST = (ADDR_W+1)'(DEPTH - 1);
   localparam logic [ADDR_W:0] c_ONE  = (ADDR_W+1)'(1);

   regbank_state_e    r_state;
   regbank_state_e    w_state_nxt;
   logic [ADDR_W:0]   r_cnt;
   logic [ADDR_W:0]   w_cnt_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_CLEAR;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      o_clr_we    = 1'b0;
      if (r_state == ST_CLEAR) begin
         o_clr_we  = !rst;
         w_cnt_nxt = r_cnt + c_ONE;
         if (r_cnt == c_LAST) begin
            w_state_nxt = ST_READY;
         end
      end
   end

   assign o_busy     = (r_state == ST_CLEAR);
   assign o_clr_addr = r_cnt[ADDR_W-1:0];

endmodule

`default_nettype wire

// File: rtl/regbank_bypass.sv
//------------------------------------------------------------------------------
// regbank_bypass : 2R/1W register bank, r0 hardwired to zero, cleared after reset.
// Define REGBANK_BYPASS_EN to forward same-edge write data onto the read ports.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module regbank_bypass
   import regbank_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DEPTH  = 1 << ADDR_W
) (
   input  logic              clk,
   input  logic              R,
   input  logic [ADDR_W-1:0] AdrA,
   input  logic [ADDR_W-1:0] AdrB,
   input  logic [ADDR_W-1:0] AdrC,
   input  logic [DATA_W-1:0] C,
   input  logic              W,
   output logic [DATA_W-1:0] A,
   output logic [DATA_W-1:0] B,
   output logic              busy
);

   localparam logic [ADDR_W:0]   c_DEPTH = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] c_ZERO  = ADDR_W'(ZERO_REG);

   logic [DATA_W-1:0] r_mem [0:DEPTH-1];
   logic [DATA_W-1:0] r_a;
   logic [DATA_W-1:0] r_b;

   logic              w_busy;
   logic              w_clr_we;
   logic [ADDR_W-1:0] w_clr_addr;
   logic              w_we;
   logic              w_vld_a;
   logic              w_vld_b;
   logic              w_fwd_a;
   logic              w_fwd_b;
   logic [DATA_W-1:0] w_rd_a;
   logic [DATA_W-1:0] w_rd_b;

   regbank_clr_seq #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_clr_seq (
      .clk        (clk),
      .rst        (R),
      .o_busy     (w_busy),
      .o_clr_we   (w_clr_we),
      .o_clr_addr (w_clr_addr)
   );

   // Only nonzero, in-range addresses are backed by storage
   assign w_we    = W && !R && !w_busy && (AdrC != c_ZERO) && ({1'b0, AdrC} < c_DEPTH);
   assign w_vld_a = (AdrA != c_ZERO) && ({1'b0, AdrA} < c_DEPTH);
   assign w_vld_b = (AdrB != c_ZERO) && ({1'b0, AdrB} < c_DEPTH);

`ifdef REGBANK_BYPASS_EN
   assign w_fwd_a = W && (AdrC == AdrA);
   assign w_fwd_b = W && (AdrC == AdrB);
`else
   assign w_fwd_a = 1'b0;
   assign w_fwd_b = 1'b0;
`endif

   assign w_rd_a = !w_vld_a ? '0 : (w_fwd_a ? C : r_mem[AdrA]);
   assign w_rd_b = !w_vld_b ? '0 : (w_fwd_b ? C : r_mem[AdrB]);

   always_ff @(posedge clk) begin
      if (!R) begin
         if (w_clr_we) begin
            r_mem[w_clr_addr] <= '0;
         end else if (w_we) begin
            r_mem[AdrC] <= C;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (R || w_busy) begin
         r_a <= '0;
         r_b <= '0;
      end else begin
         r_a <= w_rd_a;
         r_b <= w_rd_b;
      end
   end

   assign A    = r_a;
   assign B    = r_b;
   assign busy = w_busy;

endmodule

`default_nettype wire

// File: doc/regbank_bypass.md
# regbank_bypass

Parametrised two-read/one-write register bank for the MIPS datapath, sitting between decode (read addresses) and write-back (write address/data). Replaces combinational reset gating with a cycle-accurate clear sequencer that zeroes every entry after reset and holds off use until done. Register 0 is hardwired to zero. Same-cycle write-to-read forwarding is compile-time selectable.

## Interface
Parameters:
- DATA_W, 32, width of each register and of the A/B/C data ports
- ADDR_W, 5, address width
- DEPTH, 1<<ADDR_W, number of entries; must be ≤ 2**ADDR_W and ≥ 2

Ports:
- clk  in  1  clock; all state updates on the rising edge
- R  in  1  reset, synchronous, active-high
- AdrA  in  ADDR_W  read port A address
- AdrB  in  ADDR_W  read port B address
- AdrC  in  ADDR_W  write address
- C  in  DATA_W  write data
- W  in  1  write enable, sampled at the rising edge
- A  out  DATA_W  read data A, registered
- B  out  DATA_W  read data B, registered
- busy  out  1  high while the clear sequencer runs; the bank ignores W and forces A/B to 0

## Operation
- FSM states: CLEAR, READY. Clear counter cnt is ADDR_W+1 bits wide, so DEPTH = 2**ADDR_W can be represented.
- R=1 at an edge, from any state: state←CLEAR, cnt←0, A←0, B←0, busy←1. Memory is untouched while R is held.
- CLEAR with R=0: mem[cnt]←0, cnt←cnt+1. The edge that clears entry DEPTH-1 sets state←READY and busy←0. A and B stay 0. W is ignored.
- READY, write: if W=1 and AdrC≠0 and AdrC<DEPTH, then mem[AdrC]←C. A write to address 0 or out of range is dropped.
- READY, read: A←rd(AdrA), B←rd(AdrB).
  - rd(x) = 0 if x=0 or x≥DEPTH.
  - Otherwise, with forwarding compiled in, rd(x) = C if W=1 and AdrC=x.
  - Otherwise rd(x) = mem[x], the pre-edge contents.
- Simultaneous events:
  - R beats W and any in-progress clear. R mid-clear restarts at cnt=0.
  - AdrA=AdrB is legal; both ports return the same value.
- No arithmetic beyond the cnt increment. Data passes through unmodified at full DATA_W.

## Timing
- Reset values: A=0, B=0, busy=1, state=CLEAR, cnt=0.
- Clear duration: exactly DEPTH edges after the first edge with R=0. busy is low starting at the DEPTH-th such edge.
- Read latency: 1 cycle. Addresses presented before edge k appear on A/B after edge k.
- Write latency: visible to a non-forwarded read at edge k+1 or later. With forwarding it is also visible at the same edge k.
- busy is registered and glitch-free. Consumers must not issue reads or writes while busy=1.

## Configuration
- REGBANK_BYPASS_EN defined: the same-edge W/AdrC match forwards C onto A and/or B. The read-after-write hazard needs no pipeline stall.
- REGBANK_BYPASS_EN undefined: no comparator in the read path. A same-edge read returns the old contents, and the new value is visible one cycle later.

## Structure
- Shared package regbank_pkg:
  - FSM state encoding (ST_CLEAR, ST_READY)
  - default DATA_W/ADDR_W constants
  - ZERO_REG = 0
- One sub-module, regbank_clr_seq: the FSM plus the counter. It outputs busy, the clear write enable and the clear address.
- The top-level holds the memory array, write mux (clear versus W), read muxes, forwarding logic and A/B registers.

## Test plan
- Reset then clear: R=1 for 3 cycles, then R=0. busy stays 1 for exactly 32 edges (DEPTH=32) and falls at the 32nd. All reads then return 0x00000000.
- Write/read: at edge k, W=1, AdrC=5, C=0xDEADBEEF. At edge k+1, AdrA=5 gives A=0xDEADBEEF after k+1. Register 0: W=1, AdrC=0, C=0xFFFFFFFF, then AdrA=0 gives A=0.
- Forwarding: at edge k, W=1, AdrC=7, C=0x12345678, AdrA=AdrB=7, mem[7] previously 0x1.
  - With REGBANK_BYPASS_EN: A=B=0x12345678 after edge k.
  - Without it: A=B=0x1 after edge k, and 0x12345678 after edge k+1.
- Writes during busy: during clear, W=1, AdrC=3, C=0xAAAA5555. After busy falls, AdrA=3 gives A=0.
- Reset mid-clear: assert R at cnt=10, then release. busy stays 1 for a fresh 32 edges. A value written before reset to register 20 reads back 0.
- Parameter sweep: DATA_W=16, ADDR_W=3, DEPTH=6.
  - Clear takes 6 edges.
  - Writes to AdrC=6 or 7 are dropped; reads of those addresses return 0.
  - Write 0xBEEF to register 5 and read it back as 0xBEEF.
